// File: rtl/date_bcd_formatter_if.sv
// Date bus between the calendar counter (master) and the BCD formatter (slave).
// The formatter returns packed BCD digits plus busy/valid/err status.
interface date_bcd_formatter_if #(
    parameter int YEAR_BITS = 14
);
    logic                 start;
    logic [4:0]           dd;
    logic [3:0]           mm;
    logic [YEAR_BITS-1:0] yyyy;
    logic [7:0]           bcd_day;
    logic [7:0]           bcd_mon;
    logic [15:0]          bcd_year;
    logic                 busy;
    logic                 valid;
    logic                 err;

    modport master (
        output start, dd, mm, yyyy,
        input  bcd_day, bcd_mon, bcd_year, busy, valid, err
    );

    modport slave (
        input  start, dd, mm, yyyy,
        output bcd_day, bcd_mon, bcd_year, busy, valid, err
    );
endinterface

// File: rtl/date_bcd_formatter.sv
// Snapshots a dd/mm/yyyy date and converts each field to packed BCD with a
// shared sequential double-dabble loop, one field bit per clock.
module date_bcd_formatter #(
    parameter int YEAR_BITS    = 14,
    parameter bit AUTO_REFRESH = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    date_bcd_formatter_if.slave bus
);
    localparam int CW = $clog2(YEAR_BITS + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [4:0]           snap_dd, sh_dd;
    logic [3:0]           snap_mm, sh_mm;
    logic [YEAR_BITS-1:0] snap_yy, sh_yy;
    logic [7:0]           acc_day, acc_mon;
    logic [15:0]          acc_yr;
    logic [7:0]           day_adj, mon_adj;
    logic [15:0]          yr_adj;
    logic [7:0]           bcd_day_q, bcd_mon_q;
    logic [15:0]          bcd_year_q;
    logic                 valid_q, err_q;
    logic                 busy;
    logic                 trigger, date_ok, last_iter;

    function automatic logic [3:0] adj4(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // A 5-bit day cannot exceed 31, so only zero needs rejecting.
    always_comb begin
        trigger   = bus.start ||
                    (AUTO_REFRESH && ({bus.dd, bus.mm, bus.yyyy} != {snap_dd, snap_mm, snap_yy}));
        date_ok   = (bus.dd != 5'd0) && (bus.mm != 4'd0) && (bus.mm <= 4'd12) &&
                    (32'(bus.yyyy) <= 32'd9999);
        last_iter = (cnt == CW'(YEAR_BITS - 1));
        day_adj   = {adj4(acc_day[7:4]), adj4(acc_day[3:0])};
        mon_adj   = {adj4(acc_mon[7:4]), adj4(acc_mon[3:0])};
        yr_adj    = {adj4(acc_yr[15:12]), adj4(acc_yr[11:8]),
                     adj4(acc_yr[7:4]),   adj4(acc_yr[3:0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger && date_ok) state_nxt = CONV;
            CONV:    if (last_iter)          state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            snap_dd    <= '0;
            snap_mm    <= '0;
            snap_yy    <= '0;
            sh_dd      <= '0;
            sh_mm      <= '0;
            sh_yy      <= '0;
            acc_day    <= '0;
            acc_mon    <= '0;
            acc_yr     <= '0;
            bcd_day_q  <= '0;
            bcd_mon_q  <= '0;
            bcd_year_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: if (trigger) begin
                    // Snapshot even rejected dates so auto-refresh does not spin on them.
                    snap_dd <= bus.dd;
                    snap_mm <= bus.mm;
                    snap_yy <= bus.yyyy;
                    if (date_ok) begin
                        sh_dd   <= bus.dd;
                        sh_mm   <= bus.mm;
                        sh_yy   <= bus.yyyy;
                        acc_day <= '0;
                        acc_mon <= '0;
                        acc_yr  <= '0;
                        cnt     <= '0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                CONV: begin
                    cnt    <= cnt + CW'(1);
                    acc_yr <= {yr_adj[14:0], sh_yy[YEAR_BITS-1]};
                    sh_yy  <= sh_yy << 1;
                    // Shorter fields finish early and then hold their digits.
                    if (cnt < CW'(5)) begin
                        acc_day <= {day_adj[6:0], sh_dd[4]};
                        sh_dd   <= sh_dd << 1;
                    end
                    if (cnt < CW'(4)) begin
                        acc_mon <= {mon_adj[6:0], sh_mm[3]};
                        sh_mm   <= sh_mm << 1;
                    end
                end
                DONE: begin
                    bcd_day_q  <= acc_day;
                    bcd_mon_q  <= acc_mon;
                    bcd_year_q <= acc_yr;
                    valid_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd_day  = bcd_day_q;
    assign bus.bcd_mon  = bcd_mon_q;
    assign bus.bcd_year = bcd_year_q;
    assign bus.busy     = busy;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_date_bcd_formatter.sv
// Directed bench for date_bcd_formatter: one manual-start instance and one
// auto-refresh instance sharing clock and reset.
module tb_date_bcd_formatter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   lat, bn, nv;

    always #5 clk = ~clk;

    date_bcd_formatter_if #(.YEAR_BITS(14)) bus0 ();
    date_bcd_formatter_if #(.YEAR_BITS(14)) bus1 ();

    date_bcd_formatter #(.YEAR_BITS(14), .AUTO_REFRESH(1'b0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    date_bcd_formatter #(.YEAR_BITS(14), .AUTO_REFRESH(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [4:0] d, input logic [3:0] m, input logic [13:0] y, input logic s);
        bus0.dd    = d;
        bus0.mm    = m;
        bus0.yyyy  = y;
        bus0.start = s;
    endtask

    // Counts clocks from the trigger edge until valid, bounded at 40.
    task automatic wait_valid(input bit sel, output int l, output int b);
        l = 0;
        b = 0;
        while (((sel ? bus1.valid : bus0.valid) !== 1'b1) && l < 40) begin
            if ((sel ? bus1.busy : bus0.busy) === 1'b1) b++;
            tick();
            l++;
        end
    endtask

    task automatic count_valid(input bit sel, input int cycles, output int v);
        v = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if ((sel ? bus1.valid : bus0.valid) === 1'b1) v++;
        end
    endtask

    task automatic check_out(input bit sel, input string tag,
                             input logic [7:0] ed, input logic [7:0] em, input logic [15:0] ey);
        chk({tag, "_day"},  32'(sel ? bus1.bcd_day  : bus0.bcd_day),  32'(ed));
        chk({tag, "_mon"},  32'(sel ? bus1.bcd_mon  : bus0.bcd_mon),  32'(em));
        chk({tag, "_year"}, 32'(sel ? bus1.bcd_year : bus0.bcd_year), 32'(ey));
    endtask

    task automatic conv0(input logic [4:0] d, input logic [3:0] m, input logic [13:0] y, input string tag,
                         input logic [7:0] ed, input logic [7:0] em, input logic [15:0] ey);
        int l, b;
        drive0(d, m, y, 1'b1);
        tick();
        bus0.start = 1'b0;
        wait_valid(1'b0, l, b);
        chk({tag, "_latency"}, 32'(l), 32'd15);
        chk({tag, "_busy_clks"}, 32'(b), 32'd15);
        chk({tag, "_err_at_valid"}, 32'(bus0.err), 32'd0);
        check_out(1'b0, tag, ed, em, ey);
        tick();
        chk({tag, "_valid_one_clk"}, 32'(bus0.valid), 32'd0);
        chk({tag, "_busy_after"}, 32'(bus0.busy), 32'd0);
    endtask

    task automatic rej0(input logic [4:0] d, input logic [3:0] m, input logic [13:0] y, input string tag,
                        input logic [7:0] ed, input logic [7:0] em, input logic [15:0] ey);
        int v;
        drive0(d, m, y, 1'b1);
        tick();
        bus0.start = 1'b0;
        chk({tag, "_err"},   32'(bus0.err),   32'd1);
        chk({tag, "_valid"}, 32'(bus0.valid), 32'd0);
        chk({tag, "_busy"},  32'(bus0.busy),  32'd0);
        tick();
        chk({tag, "_err_pulse"}, 32'(bus0.err), 32'd0);
        count_valid(1'b0, 20, v);
        chk({tag, "_no_valid"}, 32'(v), 32'd0);
        check_out(1'b0, {tag, "_held"}, ed, em, ey);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive0(5'd0, 4'd0, 14'd0, 1'b0);
        bus1.dd = 5'd0; bus1.mm = 4'd0; bus1.yyyy = 14'd0; bus1.start = 1'b0;

        // Reset state
        tick(); tick();
        check_out(1'b0, "rst_held", 8'h00, 8'h00, 16'h0000);
        chk("rst_busy",  32'(bus0.busy),  32'd0);
        chk("rst_valid", 32'(bus0.valid), 32'd0);
        chk("rst_err",   32'(bus0.err),   32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(bus0.busy), 32'd0);
        chk("post_rst_auto_busy", 32'(bus1.busy), 32'd0);

        // Leap day, extremes, and an unchecked month length
        conv0(5'd29, 4'd2,  14'd2024, "d29022024", 8'h29, 8'h02, 16'h2024);
        conv0(5'd31, 4'd12, 14'd9999, "d31129999", 8'h31, 8'h12, 16'h9999);
        conv0(5'd1,  4'd1,  14'd0,    "d01010000", 8'h01, 8'h01, 16'h0000);

        // Rejections keep the last result
        rej0(5'd0,  4'd5,  14'd2000,  "rej_dd0",   8'h01, 8'h01, 16'h0000);
        rej0(5'd10, 4'd13, 14'd2000,  "rej_mm13",  8'h01, 8'h01, 16'h0000);
        rej0(5'd10, 4'd0,  14'd2000,  "rej_mm0",   8'h01, 8'h01, 16'h0000);
        rej0(5'd10, 4'd5,  14'd10000, "rej_y10000", 8'h01, 8'h01, 16'h0000);

        conv0(5'd31, 4'd2, 14'd2023, "d31022023", 8'h31, 8'h02, 16'h2023);

        // Start while busy is ignored
        drive0(5'd15, 4'd8, 14'd1999, 1'b1);
        tick();
        bus0.start = 1'b0;
        repeat (4) tick();
        drive0(5'd20, 4'd10, 14'd2010, 1'b1);
        tick();
        bus0.start = 1'b0;
        count_valid(1'b0, 30, nv);
        chk("busy_start_one_valid", 32'(nv), 32'd1);
        check_out(1'b0, "busy_start", 8'h15, 8'h08, 16'h1999);

        // Reset mid-conversion
        drive0(5'd7, 4'd7, 14'd1777, 1'b1);
        tick();
        bus0.start = 1'b0;
        repeat (7) tick();
        chk("pre_abort_busy", 32'(bus0.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus0.busy), 32'd0);
        check_out(1'b0, "abort", 8'h00, 8'h00, 16'h0000);
        tick();
        rst = 1'b0;
        count_valid(1'b0, 20, nv);
        chk("abort_no_valid", 32'(nv), 32'd0);
        check_out(1'b0, "abort_after", 8'h00, 8'h00, 16'h0000);
        conv0(5'd12, 4'd11, 14'd2011, "d12112011", 8'h12, 8'h11, 16'h2011);

        // Auto refresh
        bus1.dd = 5'd14; bus1.mm = 4'd3; bus1.yyyy = 14'd2021;
        tick();
        wait_valid(1'b1, lat, bn);
        chk("auto14_latency", 32'(lat), 32'd15);
        check_out(1'b1, "auto14", 8'h14, 8'h03, 16'h2021);
        bus1.dd = 5'd15;
        tick();
        wait_valid(1'b1, lat, bn);
        chk("auto15_latency", 32'(lat), 32'd15);
        chk("auto15_busy_clks", 32'(bn), 32'd15);
        check_out(1'b1, "auto15", 8'h15, 8'h03, 16'h2021);
        count_valid(1'b1, 40, nv);
        chk("auto_steady_no_valid", 32'(nv), 32'd0);
        chk("auto_steady_busy", 32'(bus1.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
